// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory port,
// redirect input and the decode-side handshake.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [47:0] imem_rdata;
  logic        imem_err;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [31:0] valC;
  logic [31:0] valP;
  logic [1:0]  stat;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata, imem_err,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output icode, ifun, rA, rB, valC, valP, stat
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata, imem_err,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  icode, ifun, rA, rB, valC, valP, stat
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: requests 6 bytes at PC, decodes the
// instruction header and hands the fields to decode.
module fetch_stage (
  input  logic clk,
  input  logic reset,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {
    S_REQ,
    S_VALID,
    S_HALT
  } state_e;

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;
  localparam logic [1:0] ST_ADR = 2'd2;
  localparam logic [1:0] ST_INS = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        req_q, req_d;
  logic        vld_q, vld_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [31:0] valc_q, valc_d;
  logic [31:0] valp_q, valp_d;
  logic [1:0]  stat_q, stat_d;

  logic [7:0]  b0, b1;
  logic [2:0]  dec_len;
  logic        dec_regs;
  logic        dec_bad;
  logic [31:0] dec_valc;

  // Length, register byte and constant of the returned bytes
  always_comb begin
    b0       = bus.imem_rdata[7:0];
    b1       = bus.imem_rdata[15:8];
    dec_len  = 3'd1;
    dec_regs = 1'b0;
    dec_bad  = 1'b0;
    dec_valc = '0;
    case (b0[7:4])
      4'h0, 4'h1, 4'h9: dec_len = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin
        dec_len  = 3'd2;
        dec_regs = 1'b1;
      end
      4'h7, 4'h8: begin
        dec_len  = 3'd5;
        dec_valc = bus.imem_rdata[39:8];
      end
      4'h3, 4'h4, 4'h5: begin
        dec_len  = 3'd6;
        dec_regs = 1'b1;
        dec_valc = bus.imem_rdata[47:16];
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Next state, PC/pending redirect and output fields
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    req_d     = req_q;
    vld_d     = vld_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    valc_d    = valc_q;
    valp_d    = valp_q;
    stat_d    = stat_q;
    case (state_q)
      S_REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            pc_d   = bus.redirect_pc;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else begin
            state_d = S_VALID;
            req_d   = 1'b0;
            vld_d   = 1'b1;
            if (bus.imem_err) begin
              icode_d = 4'h1;
              ifun_d  = 4'h0;
              ra_d    = 4'hF;
              rb_d    = 4'hF;
              valc_d  = '0;
              valp_d  = '0;
              stat_d  = ST_ADR;
            end else begin
              icode_d = b0[7:4];
              ifun_d  = b0[3:0];
              ra_d    = dec_regs ? b1[7:4] : 4'hF;
              rb_d    = dec_regs ? b1[3:0] : 4'hF;
              valc_d  = dec_valc;
              valp_d  = pc_q + {29'd0, dec_len};
              if (dec_bad) begin
                stat_d = ST_INS;
              end else if (b0[7:4] == 4'h0) begin
                stat_d = ST_HLT;
              end else begin
                stat_d = ST_AOK;
              end
            end
          end
        end else if (bus.redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.redirect_pc;
        end
      end
      S_VALID: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
          req_d   = 1'b1;
          vld_d   = 1'b0;
        end else if (bus.out_ready) begin
          vld_d = 1'b0;
          if (stat_q == ST_AOK) begin
            pc_d    = valp_q;
            state_d = S_REQ;
            req_d   = 1'b1;
          end else begin
            state_d = S_HALT;
            req_d   = 1'b0;
          end
        end
      end
      S_HALT: begin
        req_d = 1'b0;
        vld_d = 1'b0;
      end
      default: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      req_q     <= 1'b1;
      vld_q     <= 1'b0;
      icode_q   <= 4'h0;
      ifun_q    <= 4'h0;
      ra_q      <= 4'hF;
      rb_q      <= 4'hF;
      valc_q    <= '0;
      valp_q    <= '0;
      stat_q    <= ST_AOK;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      req_q     <= req_d;
      vld_q     <= vld_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      valc_q    <= valc_d;
      valp_q    <= valp_d;
      stat_q    <= stat_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = vld_q;
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.rA        = ra_q;
  assign bus.rB        = rb_q;
  assign bus.valC      = valc_q;
  assign bus.valP      = valp_q;
  assign bus.stat      = stat_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, corner sequences
// and a randomized run against a reference model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  // memory model
  logic [7:0] mem [logic [31:0]];
  logic [7:0] rmem [256];
  bit rand_mode = 0;
  bit mem_en = 0;
  int lat = 2;
  bit err_en = 0;
  logic [31:0] err_addr = '0;
  logic r_ack = 0;
  logic [47:0] r_data = '0;
  logic r_err = 0;
  logic m_ack = 0;
  logic [47:0] m_data = '0;
  logic m_err = 0;
  int cnt = 0;
  int cur_lat = 1;

  assign bus.imem_ack   = mem_en ? r_ack : m_ack;
  assign bus.imem_rdata = mem_en ? r_data : m_data;
  assign bus.imem_err   = mem_en ? r_err : m_err;

  function automatic logic [7:0] rd_byte(logic [31:0] a);
    if (rand_mode) return rmem[a[7:0]];
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [47:0] rd6(logic [31:0] a);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++)
      r[8*i +: 8] = rd_byte(a + 32'(i));
    return r;
  endfunction

  task automatic put(logic [31:0] a, logic [47:0] d,
                     int n);
    for (int i = 0; i < n; i++)
      mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  initial begin : responder
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        r_ack = 0;
        cnt = 0;
      end else if (r_ack) begin
        r_ack = 0;
        cnt = 0;
      end else if (bus.imem_req) begin
        if (cnt == 0)
          cur_lat = rand_mode ?
            int'($urandom_range(1, 4)) : lat;
        cnt++;
        if (cnt >= cur_lat) begin
          r_ack = 1;
          r_data = rd6(bus.imem_addr);
          r_err = err_en && (bus.imem_addr == err_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // reference model: decode from instruction length
  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [31:0] valc, valp;
    logic [1:0]  stat;
  } exp_t;

  function automatic exp_t model(logic [31:0] pc,
                                 logic [47:0] d);
    exp_t e;
    int len_tab [16];
    logic [7:0] b [6];
    int len;
    len_tab = '{1, 1, 2, 6, 6, 6, 2, 5,
                5, 1, 2, 2, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) b[i] = d[8*i +: 8];
    e.icode = b[0][7:4];
    e.ifun = b[0][3:0];
    e.ra = 4'hF;
    e.rb = 4'hF;
    e.valc = '0;
    len = len_tab[e.icode];
    if (len == 0) begin
      e.stat = 2'd3;
      e.valp = pc + 32'd1;
    end else begin
      e.stat = (e.icode == 4'h0) ? 2'd1 : 2'd0;
      if (len == 2 || len == 6) begin
        e.ra = b[1][7:4];
        e.rb = b[1][3:0];
      end
      if (len >= 5)
        for (int k = 0; k < 4; k++)
          e.valc[8*k +: 8] = b[len - 4 + k];
      e.valp = pc + 32'(len);
    end
    return e;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [47:0] data;
    int          n;
    bit          err;
    logic [3:0]  icode, ifun, ra, rb;
    logic [31:0] valc, valp;
    logic [1:0]  stat;
  } vec_t;

  vec_t vt [14];

  task automatic do_reset();
    bus.redirect = 0;
    bus.out_ready = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic run_vec(vec_t v, int k);
    string s;
    s = $sformatf("v%0d", k);
    mem_en = 0;
    m_ack = 0;
    put(v.pc, v.data, v.n);
    err_en = v.err;
    err_addr = v.pc;
    do_reset();
    bus.redirect = 1;
    bus.redirect_pc = v.pc;
    @(negedge clk);
    bus.redirect = 0;
    mem_en = 1;
    wait_valid(s);
    chk({s, " icode"}, 32'(bus.icode), 32'(v.icode));
    chk({s, " ifun"}, 32'(bus.ifun), 32'(v.ifun));
    chk({s, " rA"}, 32'(bus.rA), 32'(v.ra));
    chk({s, " rB"}, 32'(bus.rB), 32'(v.rb));
    chk({s, " valC"}, bus.valC, v.valc);
    chk({s, " valP"}, bus.valP, v.valp);
    chk({s, " stat"}, 32'(bus.stat), 32'(v.stat));
  endtask

  task automatic accept_vec(vec_t v, int k);
    string s;
    s = $sformatf("v%0d acc", k);
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    if (v.stat == 2'd0) begin
      chk({s, " req"}, 32'(bus.imem_req), 32'd1);
      chk({s, " addr"}, bus.imem_addr, v.valp);
    end else begin
      @(negedge clk);
      chk({s, " halt req"}, 32'(bus.imem_req), 32'd0);
      chk({s, " halt vld"}, 32'(bus.out_valid), 32'd0);
      chk({s, " halt stat"}, 32'(bus.stat), 32'(v.stat));
    end
  endtask

  logic [31:0] exp_pc;
  bit halted;
  int accepts;
  exp_t e;
  logic [3:0] nib;

  initial begin
    bus.redirect = 0;
    bus.redirect_pc = '0;
    bus.out_ready = 0;

    vt[0]  = '{32'h0, 48'h12345678F330, 6, 1'b0,
               4'h3, 4'h0, 4'hF, 4'h3,
               32'h12345678, 32'h6, 2'd0};
    vt[1]  = '{32'h6, 48'h000000010070, 5, 1'b0,
               4'h7, 4'h0, 4'hF, 4'hF,
               32'h100, 32'hB, 2'd0};
    vt[2]  = '{32'h40, 48'h0, 1, 1'b0,
               4'h0, 4'h0, 4'hF, 4'hF,
               32'h0, 32'h41, 2'd1};
    vt[3]  = '{32'h100, 48'hE0, 1, 1'b0,
               4'hE, 4'h0, 4'hF, 4'hF,
               32'h0, 32'h101, 2'd3};
    vt[4]  = '{32'h300, 48'h30, 1, 1'b1,
               4'h1, 4'h0, 4'hF, 4'hF,
               32'h0, 32'h0, 2'd2};
    vt[5]  = '{32'hFFFFFFFF, 48'h10, 1, 1'b0,
               4'h1, 4'h0, 4'hF, 4'hF,
               32'h0, 32'h0, 2'd0};
    vt[6]  = '{32'h20, 48'hAB21, 2, 1'b0,
               4'h2, 4'h1, 4'hA, 4'hB,
               32'h0, 32'h22, 2'd0};
    vt[7]  = '{32'h1000, 48'h001122334480, 5, 1'b0,
               4'h8, 4'h0, 4'hF, 4'hF,
               32'h11223344, 32'h1005, 2'd0};
    vt[8]  = '{32'h50, 48'h2361, 2, 1'b0,
               4'h6, 4'h1, 4'h2, 4'h3,
               32'h0, 32'h52, 2'd0};
    vt[9]  = '{32'h60, 48'h90, 1, 1'b0,
               4'h9, 4'h0, 4'hF, 4'hF,
               32'h0, 32'h61, 2'd0};
    vt[10] = '{32'h10, 48'hDEADBEEF1540, 6, 1'b0,
               4'h4, 4'h0, 4'h1, 4'h5,
               32'hDEADBEEF, 32'h16, 2'd0};
    vt[11] = '{32'hFFFFFFFE, 48'hC7A5, 2, 1'b0,
               4'hA, 4'h5, 4'hC, 4'h7,
               32'h0, 32'h0, 2'd0};
    vt[12] = '{32'h70, 48'h01020304125F, 6, 1'b0,
               4'h5, 4'hF, 4'h1, 4'h2,
               32'h01020304, 32'h76, 2'd0};
    vt[13] = '{32'h80, 48'h12F3, 2, 1'b0,
               4'hF, 4'h3, 4'hF, 4'hF,
               32'h0, 32'h81, 2'd3};

    for (int k = 0; k < 14; k++) begin
      run_vec(vt[k], k);
      accept_vec(vt[k], k);
    end
    err_en = 0;

    // reset state, first fetch, stall, redirect, halt
    mem_en = 0;
    lat = 2;
    put(32'h0, 48'h12345678F330, 6);
    put(32'h6, 48'h000000010070, 5);
    put(32'hB, 48'h10, 1);
    put(32'h40, 48'h00, 1);
    do_reset();
    @(negedge clk);
    chk("rst req", 32'(bus.imem_req), 32'd1);
    chk("rst addr", bus.imem_addr, 32'd0);
    chk("rst vld", 32'(bus.out_valid), 32'd0);
    chk("rst stat", 32'(bus.stat), 32'd0);
    chk("rst icode", 32'(bus.icode), 32'd0);
    chk("rst ifun", 32'(bus.ifun), 32'd0);
    chk("rst rA", 32'(bus.rA), 32'hF);
    chk("rst rB", 32'(bus.rB), 32'hF);
    chk("rst valC", bus.valC, 32'd0);
    chk("rst valP", bus.valP, 32'd0);
    mem_en = 1;
    wait_valid("a0");
    chk("a0 icode", 32'(bus.icode), 32'h3);
    chk("a0 valC", bus.valC, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall vld", 32'(bus.out_valid), 32'd1);
      chk("stall valC", bus.valC, 32'h12345678);
      chk("stall rB", 32'(bus.rB), 32'h3);
      chk("stall valP", bus.valP, 32'h6);
    end
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk("a1 req", 32'(bus.imem_req), 32'd1);
    chk("a1 addr", bus.imem_addr, 32'h6);
    chk("a1 vld", 32'(bus.out_valid), 32'd0);
    wait_valid("a1");
    chk("a1 valC", bus.valC, 32'h100);
    chk("a1 valP", bus.valP, 32'hB);
    lat = 4;
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk("a2 addr", bus.imem_addr, 32'hB);
    bus.redirect = 1;
    bus.redirect_pc = 32'h40;
    @(negedge clk);
    bus.redirect = 0;
    chk("a2 addr hold", bus.imem_addr, 32'hB);
    chk("a2 req hold", 32'(bus.imem_req), 32'd1);
    wait_valid("a2");
    chk("a2 valP", bus.valP, 32'h41);
    chk("a2 stat", 32'(bus.stat), 32'd1);
    chk("a2 icode", 32'(bus.icode), 32'd0);
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    bus.redirect = 1;
    bus.redirect_pc = 32'h80;
    @(negedge clk);
    bus.redirect = 0;
    repeat (3) @(negedge clk);
    chk("halt req", 32'(bus.imem_req), 32'd0);
    chk("halt vld", 32'(bus.out_valid), 32'd0);
    chk("halt stat", 32'(bus.stat), 32'd1);

    // redirect beats out_ready in VALID
    lat = 2;
    run_vec(vt[8], 8);
    bus.redirect = 1;
    bus.redirect_pc = 32'h500;
    bus.out_ready = 1;
    @(negedge clk);
    bus.redirect = 0;
    bus.out_ready = 0;
    chk("rdv vld", 32'(bus.out_valid), 32'd0);
    chk("rdv req", 32'(bus.imem_req), 32'd1);
    chk("rdv addr", bus.imem_addr, 32'h500);

    // redirect coincident with ack
    mem_en = 0;
    do_reset();
    @(negedge clk);
    m_ack = 1;
    m_data = 48'h10;
    m_err = 0;
    bus.redirect = 1;
    bus.redirect_pc = 32'h600;
    @(negedge clk);
    m_ack = 0;
    bus.redirect = 0;
    chk("rda vld", 32'(bus.out_valid), 32'd0);
    chk("rda req", 32'(bus.imem_req), 32'd1);
    chk("rda addr", bus.imem_addr, 32'h600);
    put(32'h600, 48'h90, 1);
    mem_en = 1;
    wait_valid("rda");
    chk("rda valP", bus.valP, 32'h601);
    chk("rda icode", 32'(bus.icode), 32'h9);

    // later redirect overwrites pending one
    mem_en = 0;
    put(32'h700, 48'hAB20, 2);
    put(32'h780, 48'h10, 1);
    do_reset();
    bus.redirect = 1;
    bus.redirect_pc = 32'h700;
    @(negedge clk);
    bus.redirect_pc = 32'h780;
    @(negedge clk);
    bus.redirect = 0;
    chk("ovw addr", bus.imem_addr, 32'h0);
    mem_en = 1;
    wait_valid("ovw");
    chk("ovw valP", bus.valP, 32'h781);

    // reset mid-transaction, then a late ack
    mem_en = 0;
    do_reset();
    bus.redirect = 1;
    bus.redirect_pc = 32'h900;
    @(negedge clk);
    bus.redirect = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid addr", bus.imem_addr, 32'h0);
    chk("mid req", 32'(bus.imem_req), 32'd1);
    chk("mid vld", 32'(bus.out_valid), 32'd0);
    m_ack = 1;
    m_data = 48'h90;
    @(negedge clk);
    m_ack = 0;
    chk("late vld", 32'(bus.out_valid), 32'd1);
    chk("late icode", 32'(bus.icode), 32'h9);
    chk("late valP", bus.valP, 32'h1);

    // randomized run against the model
    rand_mode = 1;
    err_en = 0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 15) == 0)
        nib = 4'($urandom);
      else
        nib = 4'($urandom_range(1, 11));
      rmem[i] = {nib, 4'($urandom)};
    end
    mem_en = 0;
    do_reset();
    mem_en = 1;
    exp_pc = '0;
    halted = 0;
    accepts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (reset) begin
        reset = 0;
        exp_pc = '0;
        halted = 0;
        continue;
      end
      if (halted) begin
        chk("rnd halt",
            {30'd0, bus.imem_req, bus.out_valid}, 32'd0);
        bus.redirect = 0;
        bus.out_ready = 0;
        reset = 1;
        continue;
      end
      bus.redirect = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.redirect) begin
        exp_pc = bus.redirect_pc;
      end else if (bus.out_valid && bus.out_ready) begin
        e = model(exp_pc, rd6(exp_pc));
        chk("rnd icode", 32'(bus.icode), 32'(e.icode));
        chk("rnd ifun", 32'(bus.ifun), 32'(e.ifun));
        chk("rnd rA", 32'(bus.rA), 32'(e.ra));
        chk("rnd rB", 32'(bus.rB), 32'(e.rb));
        chk("rnd valC", bus.valC, e.valc);
        chk("rnd valP", bus.valP, e.valp);
        chk("rnd stat", 32'(bus.stat), 32'(e.stat));
        accepts++;
        exp_pc = e.valp;
        if (e.stat != 2'd0) halted = 1;
      end
    end
    bus.redirect = 0;
    bus.out_ready = 0;
    chk("rnd progress", 32'(accepts > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have a single clock and use synchronous, active-high reset; there are no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  byte address of the request (= PC).
REQ-006 imem_ack  input  1  memory response valid; may arrive 1..N cycles after imem_req rises.
REQ-007 imem_rdata  input  48  6 bytes from imem_addr, little-endian (byte0 = bits[7:0]).
REQ-008 imem_err  input  1  qualified by imem_ack; address fault.
REQ-009 redirect  input  1  branch/return correction from a downstream stage.
REQ-010 redirect_pc  input  32  new PC, qualified by redirect.
REQ-011 out_valid  output  1  decoded instruction fields are valid toward decode.
REQ-012 out_ready  input  1  decode accepts this cycle.
REQ-013 icode, ifun, rA, rB  output  4 each  instruction fields.
REQ-014 valC  output  32  constant word.
REQ-015 valP  output  32  next sequential PC.
REQ-016 stat  output  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.

Function
REQ-017 The FSM SHALL have states REQ, VALID and HALT; all outputs SHALL be registered.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC, held stable until the cycle in which imem_ack=1.
REQ-019 When imem_ack=1 in REQ, the block SHALL decode byte0 as icode=byte0[7:4] and ifun=byte0[3:0], latch the fields, and enter VALID on the next edge, drop imem_req, and assert out_valid.
REQ-020 Instruction length SHALL be: icode 0, 1, 9 -> 1 byte; 2, 6, A, B -> 2 bytes; 7, 8 -> 5 bytes; 3, 4, 5 -> 6 bytes; icode C-F SHALL be invalid.
REQ-021 Instructions with a register byte (2, 3, 4, 5, 6, A, B) SHALL take rA=byte1[7:4] and rB=byte1[3:0].
REQ-022 For instructions without a register byte, rA and rB SHALL be 4'hF.
REQ-023 valC SHALL be bytes 2..5 for icode 3, 4, 5; bytes 1..4 for icode 7, 8; and 0 otherwise.
REQ-024 valP SHALL equal PC + length, mod 2^32, with wrap-around permitted.
REQ-025 In VALID, out_valid SHALL be 1 and all fields SHALL hold steady until out_ready=1.
REQ-026 On the out_ready=1 edge in VALID with stat=AOK, PC SHALL become valP and the FSM SHALL return to REQ; the next imem_req rises the following cycle.
REQ-027 icode 0 SHALL produce stat=HLT; an invalid icode SHALL produce stat=INS with fields as decoded and valP=PC+1; imem_err=1 with ack SHALL produce stat=ADR with icode=1 (nop) and the remaining fields 0/F.
REQ-028 A VALID entry with stat≠AOK SHALL go to HALT on out_ready instead of REQ.
REQ-029 In HALT, imem_req=0 and out_valid=0; stat SHALL hold its last value; redirect SHALL be ignored; only reset exits HALT.
REQ-030 A redirect in VALID SHALL, on that edge, drop out_valid, set PC=redirect_pc, and go to REQ; redirect SHALL take priority over out_ready in the same cycle.
REQ-031 A redirect in REQ without ack SHALL store redirect_pc in a pending register and keep the address stable; on the ack, the data SHALL be discarded and the FSM SHALL re-enter REQ with PC=pending value.
REQ-032 A redirect coincident with ack SHALL discard the data and set PC=redirect_pc.
REQ-033 A later redirect before ack SHALL overwrite the pending value.

Reset
REQ-034 On reset, PC=0, FSM=REQ (imem_req=1 in the first cycle after reset), out_valid=0, stat=AOK, icode=ifun=0, rA=rB=F, valC=valP=0, and the pending redirect SHALL be cleared.
REQ-035 Reset SHALL take effect mid-transaction; a late imem_ack arriving after reset SHALL be treated as the response to the new PC=0 request.

Verification
REQ-036 Reset; memory at 0 = 30 F3 78 56 34 12, ack after 2 cycles -> out_valid with icode=3, rA=F, rB=3, valC=0x12345678, valP=6, stat=0.
REQ-037 Accept with out_ready held 0 for 3 cycles, then 1 -> fields stable for 3 cycles, next imem_addr=6.
REQ-038 Bytes 70 00 01 00 00 at PC=6 -> valC=0x100, valP=0x0B, rA=rB=F.
REQ-039 Redirect to 0x40 while waiting for ack at 0x0B -> the ack data is dropped, the next request goes to 0x40, and no out_valid is produced for 0x0B.
REQ-040 Byte 00 at 0x40 -> stat=1 and valP=0x41; after out_ready, enter HALT with no further imem_req; redirect is ignored.
REQ-041 Byte E0 -> stat=3, then HALT; imem_err with ack -> stat=2, then HALT; PC=0xFFFFFFFF with 1-byte nop -> valP=0.
